// File: rtl/ex_muldiv.sv
// ----------------------------------------------------------------------------
// ex_muldiv -- multi-cycle multiply/divide unit for the EX stage.
//
// Takes the registered operands and op select of a MULT/MULTU/DIV/DIVU
// instruction and produces the 64-bit {HI, LO} result. EX and upstream are
// held via md_stall_o until the one-cycle md_done_o pulse. exception_flush
// aborts any operation in flight without touching HI/LO.
//
// Configuration macro: MULDIV_FAST_MUL_EN
//   defined   : multiply is a single-cycle array multiply (IDLE -> DONE)
//   undefined : multiply uses the 32-step shift-add path (same latency as div)
//
// Ports:
//   clk              pipeline clock
//   rst              asynchronous, active-low reset
//   exception_flush  abort current operation, return to IDLE
//   md_op_valid_i    EX holds a mul/div instruction
//   md_op_i[1:0]     00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   md_src_a_i[31:0] multiplicand / dividend
//   md_src_b_i[31:0] multiplier / divisor
//   md_stall_o       hold EX and all upstream stages
//   md_done_o        one-cycle pulse, result valid on md_hi_o/md_lo_o
//   md_hi_o[31:0]    product[63:32] or remainder
//   md_lo_o[31:0]    product[31:0] or quotient
// ----------------------------------------------------------------------------
module ex_muldiv #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exception_flush,
  input  logic        md_op_valid_i,
  input  logic [1:0]  md_op_i,
  input  logic [31:0] md_src_a_i,
  input  logic [31:0] md_src_b_i,
  output logic        md_stall_o,
  output logic        md_done_o,
  output logic [31:0] md_hi_o,
  output logic [31:0] md_lo_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e      state_q, state_d;

  logic        is_div_q;     // latched op class: 1 = divide
  logic        sa_q, sb_q;   // operand signs (zero for unsigned / div-by-zero)
  logic [5:0]  cnt_q;        // iteration counter
  logic [31:0] opnd_q;       // multiplicand (mul) or divisor (div)
  logic [31:0] work_hi_q;    // accumulator (mul) or partial remainder (div)
  logic [31:0] work_lo_q;    // multiplier (mul) or dividend/quotient (div)

  // --------------------------------------------------------------------------
  // Operand preparation (only meaningful in IDLE)
  // --------------------------------------------------------------------------
  logic        op_signed;
  logic        op_div;
  logic        div_by_zero;
  logic [31:0] a_abs, b_abs;
  logic        last_iter;

  always_comb begin
    op_signed   = ~md_op_i[0];
    op_div      = md_op_i[1];
    div_by_zero = op_div && (md_src_b_i == 32'd0);
    // 0x8000_0000 wraps to itself, which gives the expected MIN/-1 result.
    a_abs       = (op_signed && md_src_a_i[31]) ? (32'd0 - md_src_a_i) : md_src_a_i;
    b_abs       = (op_signed && md_src_b_i[31]) ? (32'd0 - md_src_b_i) : md_src_b_i;
    last_iter   = (cnt_q == 6'(DIV_ITERS - 1));
  end

  // --------------------------------------------------------------------------
  // Iteration datapath
  // --------------------------------------------------------------------------
`ifndef MULDIV_FAST_MUL_EN
  logic [32:0] mul_sum;
  always_comb begin
    mul_sum = {1'b0, work_hi_q} + {1'b0, opnd_q};
  end
`else
  logic [63:0] fast_prod;
  always_comb begin
    if (op_signed) begin
      fast_prod = $signed({{32{md_src_a_i[31]}}, md_src_a_i}) *
                  $signed({{32{md_src_b_i[31]}}, md_src_b_i});
    end else begin
      fast_prod = $unsigned({32'd0, md_src_a_i}) * $unsigned({32'd0, md_src_b_i});
    end
  end
`endif

  // Restoring divide: remainder stays below the divisor, so the shifted
  // remainder always fits in 33 bits and trial[32] is the borrow.
  logic [32:0] div_shift;
  logic [32:0] div_trial;
  always_comb begin
    div_shift = {work_hi_q, work_lo_q[31]};
    div_trial = div_shift - {1'b0, opnd_q};
  end

  // Sign correction applied in FIX
  logic [63:0] fix_result;
  logic [63:0] raw_prod;
  always_comb begin
    raw_prod = {work_hi_q, work_lo_q};
    if (is_div_q) begin
      fix_result[63:32] = sa_q ? (32'd0 - work_hi_q) : work_hi_q;
      fix_result[31:0]  = (sa_q ^ sb_q) ? (32'd0 - work_lo_q) : work_lo_q;
    end else begin
      fix_result = (sa_q ^ sb_q) ? (64'd0 - raw_prod) : raw_prod;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (exception_flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (md_op_valid_i) begin
            if (op_div) begin
              state_d = S_DIV;
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              state_d = S_DONE;
`else
              state_d = S_MUL;
`endif
            end
          end
        end
`ifndef MULDIV_FAST_MUL_EN
        S_MUL:   if (last_iter) state_d = S_FIX;
`endif
        S_DIV:   if (last_iter) state_d = S_FIX;
        S_FIX:   state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    md_stall_o = md_op_valid_i && (state_q != S_DONE);
    md_done_o  = (state_q == S_DONE) && !exception_flush;
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_div_q  <= 1'b0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      cnt_q     <= 6'd0;
      opnd_q    <= 32'd0;
      work_hi_q <= 32'd0;
      work_lo_q <= 32'd0;
      md_hi_o   <= 32'd0;
      md_lo_o   <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (md_op_valid_i && !exception_flush) begin
            is_div_q  <= op_div;
            cnt_q     <= 6'd0;
            // Divide-by-zero runs as an unsigned divide of the raw dividend:
            // a zero divisor yields quotient all-ones and remainder = a.
            sa_q      <= op_signed && md_src_a_i[31] && !div_by_zero;
            sb_q      <= op_signed && md_src_b_i[31] && !div_by_zero;
            work_hi_q <= 32'd0;
            if (op_div) begin
              work_lo_q <= div_by_zero ? md_src_a_i : a_abs;
              opnd_q    <= b_abs;
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              md_hi_o   <= fast_prod[63:32];
              md_lo_o   <= fast_prod[31:0];
`else
              work_lo_q <= b_abs;
              opnd_q    <= a_abs;
`endif
            end
          end
        end
`ifndef MULDIV_FAST_MUL_EN
        S_MUL: begin
          // Add (if multiplier LSB set), then shift {acc, multiplier} right.
          if (work_lo_q[0]) begin
            work_hi_q <= mul_sum[32:1];
            work_lo_q <= {mul_sum[0], work_lo_q[31:1]};
          end else begin
            work_hi_q <= {1'b0, work_hi_q[31:1]};
            work_lo_q <= {work_hi_q[0], work_lo_q[31:1]};
          end
          cnt_q <= cnt_q + 6'd1;
        end
`endif
        S_DIV: begin
          work_hi_q <= div_trial[32] ? div_shift[31:0] : div_trial[31:0];
          work_lo_q <= {work_lo_q[30:0], ~div_trial[32]};
          cnt_q     <= cnt_q + 6'd1;
        end
        S_FIX: begin
          if (!exception_flush) begin
            md_hi_o <= fix_result[63:32];
            md_lo_o <= fix_result[31:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// ----------------------------------------------------------------------------
// tb_ex_muldiv -- directed scoreboard bench for ex_muldiv.
// The driver pushes the hand-computed {hi, lo} for each op into a queue; a
// monitor pops and compares on every md_done_o pulse.
// ----------------------------------------------------------------------------
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        exception_flush;
  logic        md_op_valid_i;
  logic [1:0]  md_op_i;
  logic [31:0] md_src_a_i;
  logic [31:0] md_src_b_i;
  logic        md_stall_o;
  logic        md_done_o;
  logic [31:0] md_hi_o;
  logic [31:0] md_lo_o;

  always #5 clk = ~clk;

  ex_muldiv dut (
    .clk             (clk),
    .rst             (rst),
    .exception_flush (exception_flush),
    .md_op_valid_i   (md_op_valid_i),
    .md_op_i         (md_op_i),
    .md_src_a_i      (md_src_a_i),
    .md_src_b_i      (md_src_b_i),
    .md_stall_o      (md_stall_o),
    .md_done_o       (md_done_o),
    .md_hi_o         (md_hi_o),
    .md_lo_o         (md_lo_o)
  );

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam int DIV_LAT = 34;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 34;
`endif

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total    = 0;
  int   bad      = 0;
  int   done_cnt = 0;
  int   txn      = 0;

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst === 1'b1 && md_done_o === 1'b1) begin
      done_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done got hi=%h lo=%h required no done", md_hi_o, md_lo_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (md_hi_o !== mon_e.hi || md_lo_o !== mon_e.lo) begin
          bad++;
          $display("FAIL result txn=%0d got hi=%h lo=%h required hi=%h lo=%h",
                   txn, md_hi_o, md_lo_o, mon_e.hi, mon_e.lo);
        end else begin
          $display("txn %0d done hi=%h lo=%h ok", txn, md_hi_o, md_lo_o);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  // Issue one op, scramble inputs while busy, check stall and latency.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo, input int lat);
    int n;
    bit got;
    bit stall_ok;
    exp_t e;
    e.hi = hi;
    e.lo = lo;
    exp_q.push_back(e);
    txn++;
    md_op_i       = op;
    md_src_a_i    = a;
    md_src_b_i    = b;
    md_op_valid_i = 1'b1;
    n        = 0;
    got      = 1'b0;
    stall_ok = 1'b1;
    while (!got && n < 200) begin
      @(negedge clk);
      if (md_done_o === 1'b1) begin
        got = 1'b1;
      end else begin
        if (md_stall_o !== 1'b1) stall_ok = 1'b0;
        @(posedge clk);
        #1;
        n++;
        md_src_a_i = $urandom;
        md_src_b_i = $urandom;
        md_op_i    = 2'($urandom_range(3, 0));
      end
    end
    chk("done_seen", 64'(got), 64'd1);
    chk("latency", 64'(n), 64'(lat));
    chk("stall_while_busy", 64'(stall_ok), 64'd1);
    chk("stall_at_done", 64'(md_stall_o), 64'd0);
    @(posedge clk);
    #1;
    md_op_valid_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst             = 1'b0;
    exception_flush = 1'b0;
    md_op_valid_i   = 1'b0;
    md_op_i         = 2'b00;
    md_src_a_i      = 32'd0;
    md_src_b_i      = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_hi", 64'(md_hi_o), 64'd0);
    chk("reset_lo", 64'(md_lo_o), 64'd0);
    chk("reset_done", 64'(md_done_o), 64'd0);
    chk("reset_stall", 64'(md_stall_o), 64'd0);
    @(posedge clk);
    #1;

    // Directed vectors (back-to-back: each starts one cycle after DONE)
    run_op(OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       DIV_LAT);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
    run_op(OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, MUL_LAT);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT);
    run_op(OP_DIVU,  32'h1234,     32'd0,        32'h1234,     32'hFFFF_FFFF, DIV_LAT);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, DIV_LAT);
    run_op(OP_DIV,   32'h8000_0000, 32'd0,       32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT);
    run_op(OP_MULT,  32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT);
    run_op(OP_DIV,   32'd100,      32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFF2, DIV_LAT);

    // Flush in cycle 10 of a divide: no done, HI/LO untouched
    md_op_i       = OP_DIV;
    md_src_a_i    = 32'd1000;
    md_src_b_i    = 32'd3;
    md_op_valid_i = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    exception_flush = 1'b1;
    @(posedge clk);
    #1;
    exception_flush = 1'b0;
    md_op_valid_i   = 1'b0;
    d0 = done_cnt;
    repeat (40) @(posedge clk);
    #1;
    chk("flush_no_done", 64'(done_cnt - d0), 64'd0);
    chk("flush_hi_kept", 64'(md_hi_o), 64'd2);
    chk("flush_lo_kept", 64'(md_lo_o), 64'hFFFF_FFF2);
    $display("txn flush: divide aborted in cycle 10");

    // Reset mid-divide: outputs clear before the next clock edge
    md_op_i       = OP_DIV;
    md_src_a_i    = 32'd50;
    md_src_b_i    = 32'd5;
    md_op_valid_i = 1'b1;
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    chk("async_reset_hi", 64'(md_hi_o), 64'd0);
    chk("async_reset_lo", 64'(md_lo_o), 64'd0);
    chk("async_reset_done", 64'(md_done_o), 64'd0);
    md_op_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    $display("txn reset: divide discarded in cycle 15");
    @(posedge clk);
    #1;

    run_op(OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, MUL_LAT);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
